// File: rtl/sar_avg_sequencer.sv
// SAR conversion sequencer: issues start pulses at a programmable period, averages
// 2^AvgLog2 completed results, and abandons conversions that exceed a watchdog limit.
module sar_avg_sequencer #(
  parameter int Resolution    = 8,
  parameter int AvgLog2       = 2,
  parameter int PeriodWidth   = 16,
  parameter int TimeoutCycles = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [PeriodWidth-1:0] period_i,
  output logic                   start_o,
  input  logic                   rdy_i,
  input  logic [Resolution-1:0]  result_i,
  output logic [Resolution-1:0]  avg_o,
  output logic                   valid_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int AccWidth = Resolution + AvgLog2;
  localparam int CntWidth = AvgLog2 + 1;
  localparam int WdWidth  = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] WindowLen = CntWidth'(1 << AvgLog2);
  localparam logic [WdWidth-1:0]  WdLimit   = WdWidth'(TimeoutCycles);

  typedef enum logic [1:0] {IDLE, START, CONVERT, WAIT} state_t;

  state_t                 state;
  logic [AccWidth-1:0]    acc;
  logic [CntWidth-1:0]    count;
  logic [PeriodWidth-1:0] period_lat;
  logic [PeriodWidth-1:0] period_cnt;
  logic [WdWidth-1:0]     wd_cnt;
  logic                   rdy_q;
  logic                   en_q;

  logic                   done_edge;
  logic                   window_full;
  logic                   period_elapsed;
  logic                   wd_expired;
  logic [AccWidth-1:0]    acc_sum;
  logic [CntWidth-1:0]    count_inc;
  logic [PeriodWidth-1:0] period_cnt_inc;
  logic [WdWidth-1:0]     wd_cnt_inc;

  // The compares look at the count after this cycle's increment, so both
  // counters measure whole cycles since the start pulse.
  always_comb begin
    done_edge      = rdy_i & ~rdy_q;
    acc_sum        = acc + AccWidth'(result_i);
    count_inc      = count + CntWidth'(1);
    window_full    = (count_inc == WindowLen);
    period_cnt_inc = (&period_cnt) ? period_cnt : period_cnt + PeriodWidth'(1);
    period_elapsed = ({1'b0, period_cnt} + (PeriodWidth + 1)'(1)) >= {1'b0, period_lat};
    wd_cnt_inc     = wd_cnt + WdWidth'(1);
    wd_expired     = (wd_cnt_inc >= WdLimit);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      start_o    <= 1'b0;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
      timeout_o  <= 1'b0;
      avg_o      <= '0;
      acc        <= '0;
      count      <= '0;
      period_lat <= '0;
      period_cnt <= '0;
      wd_cnt     <= '0;
      rdy_q      <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      rdy_q   <= rdy_i;
      en_q    <= en_i;
      valid_o <= 1'b0;
      // Dropping enable abandons the partial window; avg_o and timeout_o keep their values.
      if (state != IDLE && !en_i) begin
        state   <= IDLE;
        start_o <= 1'b0;
        busy_o  <= 1'b0;
        acc     <= '0;
        count   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (en_i && !en_q) timeout_o <= 1'b0;
            if (en_i) begin
              state      <= START;
              start_o    <= 1'b1;
              busy_o     <= 1'b1;
              period_cnt <= '0;
              wd_cnt     <= '0;
            end
          end
          START: begin
            start_o    <= 1'b0;
            period_lat <= period_i;
            period_cnt <= period_cnt_inc;
            wd_cnt     <= wd_cnt_inc;
            state      <= CONVERT;
          end
          CONVERT: begin
            period_cnt <= period_cnt_inc;
            wd_cnt     <= wd_cnt_inc;
            if (done_edge) begin
              if (window_full) begin
                avg_o   <= acc_sum[AccWidth-1:AvgLog2];
                valid_o <= 1'b1;
                acc     <= '0;
                count   <= '0;
              end else begin
                acc     <= acc_sum;
                count   <= count_inc;
              end
              state <= WAIT;
            end else if (wd_expired) begin
              timeout_o <= 1'b1;
              state     <= WAIT;
            end
          end
          WAIT: begin
            period_cnt <= period_cnt_inc;
            if (period_elapsed) begin
              state      <= START;
              start_o    <= 1'b1;
              period_cnt <= '0;
              wd_cnt     <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
